// File: rtl/serialparalelo_align_if.sv
// Bus between the serial sampler and the word aligner; the POLARITY input is
// present only when SP_POLARITY_INV_EN is defined.
interface serialparalelo_align_if #(
  parameter int unsigned WIDTH = 10
);
  logic             ENABLE;
  logic             IS;
`ifdef SP_POLARITY_INV_EN
  logic             POLARITY;
`endif
  logic [WIDTH-1:0] OP;
  logic             VALID;
  logic             IS_COMMA;
  logic             LOCKED;
  logic             REALIGN;

`ifdef SP_POLARITY_INV_EN
  modport master (
    output ENABLE, IS, POLARITY,
    input  OP, VALID, IS_COMMA, LOCKED, REALIGN
  );
  modport slave (
    input  ENABLE, IS, POLARITY,
    output OP, VALID, IS_COMMA, LOCKED, REALIGN
  );
`else
  modport master (
    output ENABLE, IS,
    input  OP, VALID, IS_COMMA, LOCKED, REALIGN
  );
  modport slave (
    input  ENABLE, IS,
    output OP, VALID, IS_COMMA, LOCKED, REALIGN
  );
`endif
endinterface

// File: rtl/serialparalelo_align.sv
// Serial-to-parallel converter with comma-based word alignment and loss/regain tracking.
// Optional input polarity inversion is enabled by defining SP_POLARITY_INV_EN.
module serialparalelo_align #(
  parameter int unsigned      WIDTH    = 10,
  parameter logic [WIDTH-1:0] COMMA_P  = WIDTH'(10'b0101111100),
  parameter int unsigned      LOSS_CNT = 3
) (
  input logic                   CLOCK,
  input logic                   RESET_N,
  serialparalelo_align_if.slave bus
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [3:0]     BadLim  = 4'(LOSS_CNT);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e           state_q, state_d;
  // Only the upper WIDTH-1 window bits are ever shifted back in, so bit 0 is not stored.
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       bad_q, bad_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             valid_q, valid_d;
  logic             comma_q, comma_d;
  logic             realign_q, realign_d;

  logic             in_bit;
  logic [WIDTH-1:0] win;
  logic             cm;
  logic [3:0]       bad_inc;

`ifdef SP_POLARITY_INV_EN
  assign in_bit = bus.IS ^ bus.POLARITY;
`else
  assign in_bit = bus.IS;
`endif

  assign win     = {in_bit, sh_q};
  assign cm      = (win == COMMA_P) || (win == ~COMMA_P);
  assign bad_inc = bad_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    bad_d     = bad_q;
    op_d      = op_q;
    valid_d   = 1'b0;
    comma_d   = 1'b0;
    realign_d = 1'b0;
    if (!bus.ENABLE) begin
      state_d = StHunt;
      sh_d    = '0;
      cnt_d   = '0;
      bad_d   = '0;
    end else begin
      sh_d = win[WIDTH-1:1];
      unique case (state_q)
        StHunt: begin
          if (cm) begin
            op_d    = win;
            valid_d = 1'b1;
            comma_d = 1'b1;
            cnt_d   = '0;
            bad_d   = '0;
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (cnt_q == CntLast) begin
            op_d    = win;
            valid_d = 1'b1;
            comma_d = cm;
            cnt_d   = '0;
            if (cm) bad_d = '0;
          end else if (cm && (bad_inc >= BadLim)) begin
            // Enough consecutive off-boundary commas: move the boundary here.
            op_d      = win;
            valid_d   = 1'b1;
            comma_d   = 1'b1;
            realign_d = 1'b1;
            cnt_d     = '0;
            bad_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cm) bad_d = bad_inc;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q   <= StHunt;
      sh_q      <= '0;
      cnt_q     <= '0;
      bad_q     <= '0;
      op_q      <= '0;
      valid_q   <= 1'b0;
      comma_q   <= 1'b0;
      realign_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      bad_q     <= bad_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      comma_q   <= comma_d;
      realign_q <= realign_d;
    end
  end

  assign bus.OP       = op_q;
  assign bus.VALID    = valid_q;
  assign bus.IS_COMMA = comma_q;
  assign bus.REALIGN  = realign_q;
  assign bus.LOCKED   = (state_q == StLocked);

endmodule

// File: tb/tb_serialparalelo_align.sv
// Self-checking bench for serialparalelo_align: word table plus hand-built bit streams
// for realign, loss filtering, enable drop and (with SP_POLARITY_INV_EN) polarity.
module tb_serialparalelo_align;

  localparam int unsigned W = 10;
  localparam logic [9:0]  K = 10'h17C;

  logic CLOCK = 1'b0;
  logic RESET_N;

  serialparalelo_align_if #(.WIDTH(W)) bus ();

  serialparalelo_align dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [9:0] op;
    logic       comma;
    logic       realign;
  } exp_t;

  typedef struct {
    logic [9:0] word;
    logic       ev;
    logic [9:0] eop;
    logic       ec;
    logic       er;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one enabled bit; an expected word is queued when this bit should complete one.
  task automatic send_bit(input logic b, input logic ev, input logic [9:0] eop,
                          input logic ec, input logic er);
    exp_t e;
    bus.ENABLE = 1'b1;
    bus.IS     = b;
    if (ev) begin
      e.op      = eop;
      e.comma   = ec;
      e.realign = er;
      exp_q.push_back(e);
    end
    @(posedge CLOCK);
    #1;
    tests++;
    if (bus.VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL valid_unexpected: got VALID=1 OP=%h, expected VALID=0", bus.OP);
      end else begin
        e = exp_q.pop_front();
        check("op", 32'(bus.OP), 32'(e.op));
        check("is_comma", 32'(bus.IS_COMMA), 32'(e.comma));
        check("realign", 32'(bus.REALIGN), 32'(e.realign));
      end
    end else begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        fails++;
        $display("FAIL valid_missing: got VALID=%b, expected VALID=1 OP=%h", bus.VALID, e.op);
      end
      check("idle_flags", 32'({bus.IS_COMMA, bus.REALIGN}), 32'd0);
    end
  endtask

  task automatic send_word(input logic [9:0] w, input logic ev, input logic [9:0] eop,
                           input logic ec, input logic er);
    for (int i = 0; i < 10; i++) begin
      send_bit(w[i], ev && (i == 9), eop, ec, er);
    end
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_word(vecs[i].word, vecs[i].ev, vecs[i].eop, vecs[i].ec, vecs[i].er);
      check("locked_table", 32'(bus.LOCKED), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    bus.ENABLE = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      #1;
      check("idle_valid", 32'(bus.VALID), 32'd0);
      check("idle_locked", 32'(bus.LOCKED), 32'd0);
    end
  endtask

  initial begin
    logic [9:0]  hist;
    logic [9:0]  kv;
    logic [9:0]  last_op;
    logic [32:0] s33;
    logic [29:0] s30;
    logic [6:0]  filler;
    logic        b;
    logic [9:0]  cand;

    vecs[0] = '{K,      1'b1, K,      1'b1, 1'b0};
    vecs[1] = '{10'h0F0, 1'b1, 10'h0F0, 1'b0, 1'b0};
    vecs[2] = '{10'h283, 1'b1, 10'h283, 1'b1, 1'b0};
    vecs[3] = '{10'h0F0, 1'b1, 10'h0F0, 1'b0, 1'b0};
    vecs[4] = '{10'h283, 1'b1, 10'h283, 1'b1, 1'b0};
    vecs[5] = '{10'h0F0, 1'b1, 10'h0F0, 1'b0, 1'b0};

    kv     = K;
    filler = 7'b1010011;  // sent LSB first: 1,1,0,0,1,0,1

    bus.ENABLE = 1'b0;
    bus.IS     = 1'b0;
`ifdef SP_POLARITY_INV_EN
    bus.POLARITY = 1'b0;
`endif
    RESET_N = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("reset_op", 32'(bus.OP), 32'd0);
    check("reset_valid", 32'(bus.VALID), 32'd0);
    check("reset_is_comma", 32'(bus.IS_COMMA), 32'd0);
    check("reset_locked", 32'(bus.LOCKED), 32'd0);
    check("reset_realign", 32'(bus.REALIGN), 32'd0);
    RESET_N = 1'b1;

    // Random bits, steered so no window ever equals a comma.
    hist = '0;
    for (int i = 0; i < 30; i++) begin
      b    = 1'($urandom_range(0, 1));
      cand = {b, hist[9:1]};
      if ((cand == K) || (cand == ~K)) b = ~b;
      hist = {b, hist[9:1]};
      send_bit(b, 1'b0, 10'h0, 1'b0, 1'b0);
    end
    check("hunt_op", 32'(bus.OP), 32'd0);
    check("hunt_locked", 32'(bus.LOCKED), 32'd0);
    idle(1);

    // First lock and two following words.
    run_table(0, 2);

    // Three extra bits, then three commas arriving 3 bits late.
    for (int i = 0; i < 33; i++) s33[i] = 1'b0;
    s33[0] = 1'b1; s33[1] = 1'b0; s33[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 10; i++) s33[3 + 10*j + i] = kv[i];
    end
    for (int p = 1; p <= 33; p++) begin
      if (p == 10)      send_bit(s33[p-1], 1'b1, 10'h3E5, 1'b0, 1'b0);
      else if (p == 20) send_bit(s33[p-1], 1'b1, 10'h3E2, 1'b0, 1'b0);
      else if (p == 30) send_bit(s33[p-1], 1'b1, 10'h3E2, 1'b0, 1'b0);
      else if (p == 33) send_bit(s33[p-1], 1'b1, K, 1'b1, 1'b1);
      else              send_bit(s33[p-1], 1'b0, 10'h0, 1'b0, 1'b0);
    end
    check("locked_after_realign", 32'(bus.LOCKED), 32'd1);
    run_table(3, 4);

    // One off-boundary comma, then an on-boundary comma; repeated so a bad
    // counter that failed to clear would reach the limit.
    s30[2:0] = 3'b101;
    for (int i = 0; i < 10; i++) s30[3 + i] = kv[i];
    for (int i = 0; i < 7; i++)  s30[13 + i] = filler[i];
    for (int i = 0; i < 10; i++) s30[20 + i] = kv[i];
    for (int r = 0; r < 3; r++) begin
      for (int p = 1; p <= 30; p++) begin
        if (p == 10)      send_bit(s30[p-1], 1'b1, 10'h3E5, 1'b0, 1'b0);
        else if (p == 20) send_bit(s30[p-1], 1'b1, 10'h29A, 1'b0, 1'b0);
        else if (p == 30) send_bit(s30[p-1], 1'b1, K, 1'b1, 1'b0);
        else              send_bit(s30[p-1], 1'b0, 10'h0, 1'b0, 1'b0);
      end
    end
    run_table(5, 5);

    // Enable drop on the fifth bit of a word.
    last_op = 10'h0F0;
    cand    = 10'h283;
    for (int i = 0; i < 4; i++) send_bit(cand[i], 1'b0, 10'h0, 1'b0, 1'b0);
    idle(4);
    check("drop_op_hold", 32'(bus.OP), 32'(last_op));
    for (int i = 0; i < 2; i++) send_word(10'h0F0, 1'b0, 10'h0, 1'b0, 1'b0);
    check("drop_op_hold2", 32'(bus.OP), 32'(last_op));
    check("drop_locked", 32'(bus.LOCKED), 32'd0);
    send_word(K, 1'b1, K, 1'b1, 1'b0);
    check("relock", 32'(bus.LOCKED), 32'd1);

`ifdef SP_POLARITY_INV_EN
    idle(1);
    bus.POLARITY = 1'b1;
    send_word(~K, 1'b1, K, 1'b1, 1'b0);
    check("pol_locked", 32'(bus.LOCKED), 32'd1);
    bus.POLARITY = 1'b0;
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
